// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

   // Operation codes, identical to the ALU operation encoding
   localparam logic [4:0] OP_MUL = 5'b00011;
   localparam logic [4:0] OP_DIV = 5'b00100;

   // Control states of the sequencer
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Bit positions inside the flag output
   localparam int FLG_ZERO   = 0;
   localparam int FLG_DIVZ   = 1;
   localparam int FLG_MULOVF = 2;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply/divide unit for the EX stage.
// MUL: shift-add over WIDTH cycles. DIV: restoring division over WIDTH cycles.
// A single 2*WIDTH accumulator is shared by both operations:
//   MUL: {partial product high, multiplier being shifted out}
//   DIV: {partial remainder, dividend being shifted out / quotient shifted in}
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] data_a,
   input  logic [WIDTH-1:0] data_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic [3:0]       flag
);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     opnd_q, opnd_d;
   logic                 is_div_q, is_div_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic [WIDTH-1:0]     result_hi_q, result_hi_d;
   logic [3:0]           flag_q, flag_d;

   logic                 op_valid;
   logic                 accept;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       div_rem_sh;
   logic [WIDTH:0]       div_diff;
   logic [2*WIDTH-1:0]   acc_step;

   assign op_valid = (op == OP_MUL) || (op == OP_DIV);
   assign accept   = (state_q != RUN) && start && op_valid;

   // One iteration of the shared datapath, applied to the current accumulator
   always_comb begin
      mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      div_rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff   = div_rem_sh - {1'b0, opnd_q};
      acc_step   = {mul_sum, acc_q[WIDTH-1:1]};
      if (is_div_q) begin
         // Remainder fits in WIDTH bits after the subtract since it is below the divisor
         if (div_rem_sh >= {1'b0, opnd_q}) begin
            acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_step = {div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   // Sequencer next-state, operand capture and result/flag update at entry to DONE
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      opnd_d      = opnd_q;
      is_div_d    = is_div_q;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      flag_d      = flag_q;

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (accept) begin
               is_div_d = (op == OP_DIV);
               cnt_d    = '0;
               if (op == OP_DIV) begin
                  opnd_d = data_b;
                  acc_d  = {{WIDTH{1'b0}}, data_a};
                  if (data_b == '0) begin
                     // Divide-by-zero short-circuits straight to DONE
                     state_d                = DONE;
                     result_d               = '1;
                     result_hi_d            = data_a;
                     flag_d                 = '0;
                     flag_d[FLG_DIVZ]       = 1'b1;
                     flag_d[FLG_ZERO]       = (result_d == '0);
                  end else begin
                     state_d = RUN;
                  end
               end else begin
                  opnd_d  = data_a;
                  acc_d   = {{WIDTH{1'b0}}, data_b};
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            acc_d = acc_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d            = DONE;
               result_d           = acc_step[WIDTH-1:0];
               result_hi_d        = acc_step[2*WIDTH-1:WIDTH];
               flag_d             = '0;
               flag_d[FLG_ZERO]   = (acc_step[WIDTH-1:0] == '0);
               flag_d[FLG_MULOVF] = !is_div_q && (acc_step[2*WIDTH-1:WIDTH] != '0);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   // State, counter, datapath and registered outputs
   always_ff @(posedge clk) begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         is_div_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         result_q    <= '0;
         result_hi_q <= '0;
         flag_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         is_div_q    <= is_div_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         flag_q      <= flag_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign result    = result_q;
   assign result_hi = result_hi_q;
   assign flag      = flag_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a result scoreboard.
module tb_muldiv_seq;

   localparam int W = 32;
   localparam logic [4:0] OP_MUL = 5'b00011;
   localparam logic [4:0] OP_DIV = 5'b00100;

   typedef struct {
      logic [W-1:0] r;
      logic [W-1:0] h;
      logic [3:0]   f;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [4:0]   op = 5'b0;
   logic [W-1:0] data_a = '0;
   logic [W-1:0] data_b = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic [W-1:0] result_hi;
   logic [3:0]   flag;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   done_cnt = 0;
   exp_t exp_q[$];

   muldiv_seq dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .data_a    (data_a),
      .data_b    (data_b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .result_hi (result_hi),
      .flag      (flag)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] o);
      exp_t e;
      logic [63:0] p;
      if (o == OP_MUL) begin
         p   = {32'b0, a} * {32'b0, b};
         e.r = p[31:0];
         e.h = p[63:32];
         e.f = {1'b0, (e.h != 0), 1'b0, (e.r == 0)};
      end else if (b == 0) begin
         e.r = '1;
         e.h = a;
         e.f = {2'b00, 1'b1, (e.r == 0)};
      end else begin
         e.r = a / b;
         e.h = a % b;
         e.f = {3'b000, (e.r == 0)};
      end
      return e;
   endfunction

   // Scoreboard: every done pulse must match the oldest expected result
   always @(negedge clk) begin
      if (done) begin
         exp_t e;
         done_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("result", 64'(result), 64'(e.r));
            check("result_hi", 64'(result_hi), 64'(e.h));
            check("flag", 64'(flag), 64'(e.f));
         end
      end
   end

   // Present a request at the current (negedge) time; it is sampled on the next rising edge
   task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] o);
      start  = 1'b1;
      op     = o;
      data_a = a;
      data_b = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = 5'b0;
   endtask

   // Count negedges after the accept edge until done; -1 on timeout
   task automatic wait_done(input int limit, output int cycles, output int busy_hi);
      busy_hi = 0;
      cycles  = -1;
      for (int k = 1; k <= limit; k++) begin
         @(negedge clk);
         if (busy) busy_hi++;
         if (done) begin
            cycles = k;
            break;
         end
      end
   endtask

   initial begin
      int k;
      int bh;
      int dc;

      // Reset state
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      check("rst_result_hi", 64'(result_hi), 64'd0);
      check("rst_flag", 64'(flag), 64'd0);

      // MUL 7 x 6: latency and busy window
      exp_q.push_back(model(32'd7, 32'd6, OP_MUL));
      drive_start(32'd7, 32'd6, OP_MUL);
      wait_done(100, k, bh);
      check("mul7x6_latency", 64'(k), 64'd33);
      check("mul7x6_busy_cycles", 64'(bh), 64'd32);

      // MUL all ones: full 64-bit product, high-word flag
      @(negedge clk);
      exp_q.push_back(model(32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MUL));
      drive_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MUL);
      wait_done(100, k, bh);
      check("mulmax_latency", 64'(k), 64'd33);
      check("mulmax_result_const", 64'(result), 64'h1);
      check("mulmax_hi_const", 64'(result_hi), 64'hFFFF_FFFE);
      check("mulmax_flag_const", 64'(flag), 64'b0100);

      // DIV 100 / 7, then DIV 5 / 9 (zero quotient)
      @(negedge clk);
      exp_q.push_back(model(32'd100, 32'd7, OP_DIV));
      drive_start(32'd100, 32'd7, OP_DIV);
      wait_done(100, k, bh);
      check("div100_7_latency", 64'(k), 64'd33);
      check("div100_7_result_const", 64'(result), 64'd14);
      check("div100_7_hi_const", 64'(result_hi), 64'd2);
      @(negedge clk);
      exp_q.push_back(model(32'd5, 32'd9, OP_DIV));
      drive_start(32'd5, 32'd9, OP_DIV);
      wait_done(100, k, bh);
      check("div5_9_latency", 64'(k), 64'd33);
      check("div5_9_flag_const", 64'(flag), 64'b0001);

      // A few more divisions with large operands
      for (int i = 0; i < 3; i++) begin
         logic [W-1:0] a;
         logic [W-1:0] b;
         @(negedge clk);
         a = $urandom;
         b = $urandom_range(1, 100000) << i * 7;
         exp_q.push_back(model(a, b, OP_DIV));
         drive_start(a, b, OP_DIV);
         wait_done(100, k, bh);
         check("divrnd_latency", 64'(k), 64'd33);
      end

      // Divide by zero: done one cycle after accept, busy never high
      @(negedge clk);
      exp_q.push_back(model(32'h1234, 32'd0, OP_DIV));
      drive_start(32'h1234, 32'd0, OP_DIV);
      wait_done(100, k, bh);
      check("divz_latency", 64'(k), 64'd1);
      check("divz_busy_cycles", 64'(bh), 64'd0);
      check("divz_result_const", 64'(result), 64'hFFFF_FFFF);
      check("divz_hi_const", 64'(result_hi), 64'h1234);

      // Start during RUN is ignored
      @(negedge clk);
      exp_q.push_back(model(32'd3, 32'd4, OP_MUL));
      drive_start(32'd3, 32'd4, OP_MUL);
      repeat (10) @(negedge clk);
      drive_start(32'd9, 32'd9, OP_MUL);
      wait_done(100, k, bh);
      check("ignored_start_latency", 64'(k), 64'd23);
      check("ignored_start_result_const", 64'(result), 64'd12);

      // Start in the DONE cycle is accepted; outputs held during the new RUN
      exp_q.push_back(model(32'd9, 32'd9, OP_MUL));
      drive_start(32'd9, 32'd9, OP_MUL);
      @(negedge clk);
      check("held_busy", 64'(busy), 64'd1);
      check("held_result", 64'(result), 64'd12);
      wait_done(100, k, bh);
      check("done_cycle_start_latency", 64'(k), 64'd32);
      check("done_cycle_start_result_const", 64'(result), 64'd81);

      // Reset in the middle of a DIV aborts it with no done pulse
      @(negedge clk);
      exp_q.push_back(model(32'd1000, 32'd3, OP_DIV));
      drive_start(32'd1000, 32'd3, OP_DIV);
      repeat (15) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_result", 64'(result), 64'd0);
      check("abort_result_hi", 64'(result_hi), 64'd0);
      check("abort_flag", 64'(flag), 64'd0);
      dc = done_cnt;
      bh = 0;
      repeat (40) begin
         @(negedge clk);
         if (busy) bh++;
      end
      check("abort_no_done", 64'(done_cnt), 64'(dc));
      check("abort_no_busy", 64'(bh), 64'd0);

      // Unknown op code is ignored
      @(negedge clk);
      drive_start(32'd5, 32'd5, 5'b00000);
      bh = 0;
      repeat (5) begin
         @(negedge clk);
         if (busy) bh++;
      end
      check("badop_no_busy", 64'(bh), 64'd0);
      check("badop_no_done", 64'(done_cnt), 64'(dc));
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
